// File: rtl/control_unit.sv
// control_unit: multicycle FETCH/DECODE/[MEM]/EXEC sequencer driving the accumulator datapath.
// Latency: 3 cycles per instruction, 4 for LD/ADD/SUB; the first FETCH comes 2 cycles after reset_in falls.
// Backpressure: none. The sequencer free-runs against fixed 1-cycle synchronous memories.
//
// Ports:
//   clock_in, reset_in          : clock, synchronous active-high reset
//   instruction_in              : program memory read data {opcode[3:0], operand}
//   flag_Z_in, flag_N_in        : datapath status flags, sampled in EXEC by branches
//   pc_out                      : program memory address
//   operand_out                 : IR operand (datapath operand and data-memory address)
//   sel_A_out/sel_B_out/op_alu_out : datapath mux and ALU controls
//   acc_wr_out, status_wr_out, acc_reset_out, status_reset_out : datapath strobes
//   data_memory_wr_out          : data memory write strobe
//   halted_out                  : high in HALT
//   retired_count_out           : retired-instruction count, built only when
//                                 CONTROL_UNIT_RETIRED_COUNT_EN is defined (else 0)
module control_unit #(
  parameter int DATA_WIDTH = 11,
  parameter int PC_WIDTH   = 8
) (
  input  logic                    clock_in,
  input  logic                    reset_in,
  input  logic [DATA_WIDTH+3:0]   instruction_in,
  input  logic                    flag_Z_in,
  input  logic                    flag_N_in,
  output logic [PC_WIDTH-1:0]     pc_out,
  output logic [DATA_WIDTH-1:0]   operand_out,
  output logic [1:0]              sel_A_out,
  output logic                    sel_B_out,
  output logic                    op_alu_out,
  output logic                    acc_wr_out,
  output logic                    status_wr_out,
  output logic                    acc_reset_out,
  output logic                    status_reset_out,
  output logic                    data_memory_wr_out,
  output logic                    halted_out,
  output logic [15:0]             retired_count_out
);

  typedef enum logic [2:0] {
    S_RST,
    S_FETCH,
    S_DECODE,
    S_MEM,
    S_EXEC,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_HLT  = 4'h0;
  localparam logic [3:0] OP_STO  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_LDI  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_ADDI = 4'h5;
  localparam logic [3:0] OP_SUB  = 4'h6;
  localparam logic [3:0] OP_SUBI = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_BNE  = 4'h9;
  localparam logic [3:0] OP_BGT  = 4'hA;
  localparam logic [3:0] OP_BGE  = 4'hB;
  localparam logic [3:0] OP_BLT  = 4'hC;
  localparam logic [3:0] OP_BLE  = 4'hD;
  localparam logic [3:0] OP_JMP  = 4'hE;

  state_t                  state_q, state_d;
  logic [PC_WIDTH-1:0]     pc_q, pc_d;
  logic [DATA_WIDTH+3:0]   ir_q, ir_d;

  logic [3:0] ir_op;
  logic [3:0] in_op;
  logic [3:0] op_dec;
  logic       dec_active;
  logic       branch_taken;
  logic       exec_en;

  assign ir_op       = ir_q[DATA_WIDTH+3:DATA_WIDTH];
  assign in_op       = instruction_in[DATA_WIDTH+3:DATA_WIDTH];
  assign pc_out      = pc_q;
  assign operand_out = ir_q[DATA_WIDTH-1:0];
  assign halted_out  = (state_q == S_HALT);

  // EXEC strobes are dropped in a cycle where reset is asserted, so a
  // store caught by reset never reaches data memory.
  assign exec_en = (state_q == S_EXEC) && !reset_in;

  // Mux/ALU selects: IR is not loaded until the end of DECODE, so DECODE
  // decodes the memory data directly; MEM and EXEC decode from IR.
  always_comb begin
    op_dec     = ir_op;
    dec_active = 1'b0;
    sel_A_out  = 2'b00;
    sel_B_out  = 1'b0;
    op_alu_out = 1'b0;
    if (state_q == S_DECODE) begin
      op_dec     = in_op;
      dec_active = 1'b1;
    end else if (state_q == S_MEM || state_q == S_EXEC) begin
      dec_active = 1'b1;
    end
    if (dec_active) begin
      case (op_dec)
        OP_LD:   sel_A_out = 2'b10;
        OP_LDI:  sel_A_out = 2'b01;
        OP_ADDI: sel_B_out = 1'b1;
        OP_SUB:  op_alu_out = 1'b1;
        OP_SUBI: begin
          sel_B_out  = 1'b1;
          op_alu_out = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (ir_op)
      OP_BEQ:  branch_taken = flag_Z_in;
      OP_BNE:  branch_taken = !flag_Z_in;
      OP_BGT:  branch_taken = !flag_Z_in && !flag_N_in;
      OP_BGE:  branch_taken = !flag_N_in;
      OP_BLT:  branch_taken = flag_N_in;
      OP_BLE:  branch_taken = flag_Z_in || flag_N_in;
      OP_JMP:  branch_taken = 1'b1;
      default: branch_taken = 1'b0;
    endcase
  end

  // Next-state, PC/IR and strobes.
  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    ir_d               = ir_q;
    acc_wr_out         = 1'b0;
    status_wr_out      = 1'b0;
    acc_reset_out      = 1'b0;
    status_reset_out   = 1'b0;
    data_memory_wr_out = 1'b0;
    case (state_q)
      S_RST: begin
        acc_reset_out    = 1'b1;
        status_reset_out = 1'b1;
        pc_d             = '0;
        ir_d             = '0;
        state_d          = S_FETCH;
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d = instruction_in;
        if (in_op == OP_LD || in_op == OP_ADD || in_op == OP_SUB) begin
          state_d = S_MEM;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_MEM: state_d = S_EXEC;
      S_EXEC: begin
        case (ir_op)
          OP_STO: data_memory_wr_out = exec_en;
          OP_LD, OP_LDI: acc_wr_out = exec_en;
          OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
            acc_wr_out    = exec_en;
            status_wr_out = exec_en;
          end
          default: ;
        endcase
        if (ir_op == OP_HLT) begin
          // HLT leaves PC pointing at itself.
          state_d = S_HALT;
        end else begin
          state_d = S_FETCH;
          pc_d    = branch_taken ? ir_q[PC_WIDTH-1:0] : pc_q + PC_WIDTH'(1);
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= S_RST;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

`ifdef CONTROL_UNIT_RETIRED_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Every EXEC retires one instruction, HLT included; wraps at 16 bits.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_EXEC) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign retired_count_out = cnt_q;
`else
  assign retired_count_out = 16'd0;
`endif

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle sequencer for the accumulator datapath. It fetches instructions from a synchronous program memory, decodes a 4-bit opcode, and drives every datapath control: accumulator, status, muxes and ALU operation. It also drives the data-memory write strobe, resolves conditional branches from flags Z/N and maintains the program counter. It sits between program memory and the datapath; the datapath's `operand_in` is fed from this block's `operand_out`.

## Interface
- `DATA_WIDTH`, 11, operand/data width; the instruction word is `4 + DATA_WIDTH` bits.
- `PC_WIDTH`, 8, program counter width; must satisfy `PC_WIDTH <= DATA_WIDTH`.

Ports:
- `clock_in`, in, 1: single clock; all state updates on the rising edge.
- `reset_in`, in, 1: synchronous, active-high reset.
- `instruction_in`, in, `4+DATA_WIDTH`: program memory read data.
  - Opcode is `[DATA_WIDTH+3:DATA_WIDTH]`; operand is `[DATA_WIDTH-1:0]`.
- `flag_Z_in`, `flag_N_in`, in, 1 each: datapath status flags.
- `pc_out`, out, `PC_WIDTH`: program memory address.
- `operand_out`, out, `DATA_WIDTH`: IR operand field; feeds the datapath operand and data-memory address.
- `sel_A_out`, out, 2: accumulator input select. 00 = ALU, 01 = ext (immediate), 10 = data memory; 11 is unused.
- `sel_B_out`, out, 1: ALU B select. 0 = data memory, 1 = ext.
- `op_alu_out`, out, 1: 0 = add, 1 = subtract.
- `acc_wr_out`, `status_wr_out`, `acc_reset_out`, `status_reset_out`, out, 1 each: datapath strobes.
- `data_memory_wr_out`, out, 1: data memory write strobe; the write data is the datapath `data_out`.
- `halted_out`, out, 1: high while in state HALT.
- `retired_count_out`, out, 16: retired-instruction counter (see Configuration).

## Operation
- **States:** RST, FETCH, DECODE, MEM, EXEC, HALT.
- **RST:**
  - Assert `acc_reset_out` and `status_reset_out`.
  - Clear PC and IR.
  - Go to FETCH.
- **FETCH:** `pc_out` = PC is presented; memory returns the instruction next cycle. Go to DECODE.
- **DECODE:**
  - IR ← `instruction_in`.
  - Go to MEM if the opcode is LD/ADD/SUB; otherwise go to EXEC.
- **MEM:** no strobes; the data-memory read completes using `operand_out` as the address. Go to EXEC.
- **EXEC:**
  - Assert the opcode's strobes for exactly one cycle.
  - Update PC and increment the retired counter.
  - Go to FETCH; HLT goes to HALT instead.
- **Opcodes:**
  - 0 HLT.
  - 1 STO: `data_memory_wr_out` = 1.
  - 2 LD: sel_A = 10, `acc_wr_out` = 1.
  - 3 LDI: sel_A = 01, `acc_wr_out` = 1.
  - 4 ADD: sel_B = 0, op = 0.
  - 5 ADDI: sel_B = 1, op = 0.
  - 6 SUB: sel_B = 0, op = 1.
  - 7 SUBI: sel_B = 1, op = 1.
  - ADD/ADDI/SUB/SUBI all assert sel_A = 00, `acc_wr_out` = 1 and `status_wr_out` = 1.
  - 8 BEQ: taken if Z.
  - 9 BNE: taken if !Z.
  - A BGT: taken if !Z & !N.
  - B BGE: taken if !N.
  - C BLT: taken if N.
  - D BLE: taken if Z | N.
  - E JMP: always taken.
  - F NOP.
- **PC update:**
  - Taken branch: PC ← `operand[PC_WIDTH-1:0]`.
  - Otherwise: PC ← PC + 1, wrapping modulo 2^PC_WIDTH (PC = all-ones goes to 0).
- **Flags:** flags are sampled in EXEC. Only ADD/ADDI/SUB/SUBI update them; LD/LDI leave Z/N unchanged.
- **HALT:** all strobes are 0 and PC is frozen. The block stays in HALT until `reset_in`.
- **Strobe defaults:** in every state other than EXEC and RST, all strobes are 0. `sel_A_out`, `sel_B_out` and `op_alu_out` hold their decoded values from DECODE through EXEC; they are 0 elsewhere.

## Timing
- **Reset values:** `reset_in` high at any edge, in any state, forces the following:
  - state = RST, PC = 0, IR = 0, counter = 0.
  - All outputs 0 except `acc_reset_out` = `status_reset_out` = 1 while in RST.
  - A store or write pending in EXEC is suppressed if `reset_in` is high in that cycle (strobes are gated by !`reset_in`).
- **Latency:**
  - 3 cycles per instruction (FETCH, DECODE, EXEC).
  - 4 cycles for LD/ADD/SUB (adds MEM).
  - The first FETCH is 2 cycles after `reset_in` falls (RST occupies 1 cycle).
- **Memory timing:** program memory and data memory are synchronous-read with 1-cycle latency. The data-memory write commits at the EXEC edge.
- **Flag timing:** flags are visible to a branch in the instruction immediately after the ALU op, because the status register updates at the end of that op's EXEC.

## Configuration
- **Macro:** `CONTROL_UNIT_RETIRED_COUNT_EN`.
- **Defined:** `retired_count_out` is a 16-bit counter that increments at each EXEC, including HLT. It wraps from 0xFFFF to 0 and is cleared by reset.
- **Undefined:** no counter logic is built and `retired_count_out` is constant 0.

## Test plan
- **Reset:** hold `reset_in` for 2 cycles, then release → RST strobes high for 1 cycle, then `pc_out` = 0 in FETCH, and `halted_out` = 0.
- **Load/add/store:** program LDI 5; ADDI 3; STO 0x10; HLT → `acc_wr_out` pulses in cycles 3 and 6. The data-memory write occurs at cycle 9 with address 0x10 and data 8. Then `halted_out` = 1 and `pc_out` stays at 3.
- **Branch taken:** LDI 2; SUBI 2; BEQ 0x20 → PC = 0x20 after the BEQ EXEC. With LDI 3 instead, PC = 3.
- **Memory read cycle count:** ADD 0x05 with mem[5] = 7 and acc = 1 → MEM state is present (4-cycle instruction), acc = 8 and Z = 0.
- **PC wrap:** NOP at address 0xFF → next `pc_out` = 0x00.
- **Reset mid-operation:** assert `reset_in` during the EXEC of STO → no `data_memory_wr_out` pulse and PC = 0. With the macro defined, `retired_count_out` = 0.
